// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder: buffered stream transmitter for one PE-group operand
// channel. The host fills a local buffer through a write port; a start
// command replays a window of that buffer BlockCount times over a
// valid/ready handshake toward the PE group.
module pe_stream_feeder #(
  parameter int DataWidth       = 32,
  parameter int BufferWidth     = 4,
  parameter int BufferSize      = 16,
  parameter int BlockCount      = 4,
  parameter int BlockCountWidth = 2
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   WrEn,
  input  logic [BufferWidth-1:0] WrAddr,
  input  logic [DataWidth-1:0]   WrData,
  input  logic                   Start,
  input  logic [BufferWidth-1:0] StartAddr,
  input  logic [BufferWidth:0]   Length,
  output logic                   Busy,
  output logic                   Done,
  output logic [DataWidth-1:0]   DataOut,
  output logic                   DataOutValid,
  input  logic                   DataOutRdy,
  output logic                   DataOutLast
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BufferWidth:0]       SizeVal  = (BufferWidth+1)'(BufferSize);
  localparam logic [BufferWidth:0]       LenOne   = (BufferWidth+1)'(1);
  localparam logic [BufferWidth-1:0]     AddrOne  = BufferWidth'(1);
  localparam logic [BlockCountWidth-1:0] PassLast = BlockCountWidth'(BlockCount - 1);
  localparam logic [BlockCountWidth-1:0] PassOne  = BlockCountWidth'(1);

  state_t state, state_nxt;

  logic [DataWidth-1:0]       mem [BufferSize];
  logic [BufferWidth-1:0]     addr;
  logic [BufferWidth-1:0]     base;
  logic [BufferWidth:0]       len;
  logic [BufferWidth:0]       word_cnt;
  logic [BlockCountWidth-1:0] pass_cnt;
  logic [DataWidth-1:0]       data_q;
  logic                       valid_q;

  logic                       start_ok;
  logic                       accept;
  logic                       hs;
  logic                       wr_ok;
  logic                       word_last;
  logic                       pass_last;
  logic [BufferWidth-1:0]     addr_inc;

  assign start_ok  = Start && (Length != '0) && (Length <= SizeVal);
  assign word_last = (word_cnt == (len - LenOne));
  assign pass_last = (pass_cnt == PassLast);
  assign addr_inc  = addr + AddrOne;

  // State register
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    hs        = 1'b0;
    wr_ok     = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
        // A write colliding with an accepted start is dropped so the first
        // word read out is the pre-existing buffer content.
        wr_ok = WrEn && !start_ok;
      end
      SEND: begin
        if (valid_q && DataOutRdy) begin
          hs = 1'b1;
          if (word_last && pass_last) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer storage, window pointers and registered stream output
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int unsigned i = 0; i < BufferSize; i++) mem[i] <= '0;
      addr     <= '0;
      base     <= '0;
      len      <= '0;
      word_cnt <= '0;
      pass_cnt <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (wr_ok) mem[WrAddr] <= WrData;
      if (accept) begin
        base     <= StartAddr;
        len      <= Length;
        addr     <= StartAddr;
        word_cnt <= '0;
        pass_cnt <= '0;
        data_q   <= mem[StartAddr];
        valid_q  <= 1'b1;
      end else if (hs) begin
        if (!word_last) begin
          addr     <= addr_inc;
          word_cnt <= word_cnt + LenOne;
          data_q   <= mem[addr_inc];
        end else if (!pass_last) begin
          // Pass boundary reloads the window head in the same cycle: no bubble.
          addr     <= base;
          word_cnt <= '0;
          pass_cnt <= pass_cnt + PassOne;
          data_q   <= mem[base];
        end else begin
          valid_q  <= 1'b0;
        end
      end
    end
  end

  assign DataOut      = data_q;
  assign DataOutValid = valid_q;
  assign DataOutLast  = valid_q && word_last;
  assign Busy         = (state != IDLE);
  assign Done         = (state == DONE);

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Directed testbench for pe_stream_feeder.
module tb_pe_stream_feeder;

  logic        clk;
  logic        aclr;
  logic        WrEn;
  logic [3:0]  WrAddr;
  logic [31:0] WrData;
  logic        Start;
  logic [3:0]  StartAddr;
  logic [4:0]  Length;
  logic        Busy;
  logic        Done;
  logic [31:0] DataOut;
  logic        DataOutValid;
  logic        DataOutRdy;
  logic        DataOutLast;

  int n_checks = 0;
  int n_pass   = 0;

  pe_stream_feeder #(
    .DataWidth(32),
    .BufferWidth(4),
    .BufferSize(16),
    .BlockCount(4),
    .BlockCountWidth(2)
  ) dut (
    .clk(clk),
    .aclr(aclr),
    .WrEn(WrEn),
    .WrAddr(WrAddr),
    .WrData(WrData),
    .Start(Start),
    .StartAddr(StartAddr),
    .Length(Length),
    .Busy(Busy),
    .Done(Done),
    .DataOut(DataOut),
    .DataOutValid(DataOutValid),
    .DataOutRdy(DataOutRdy),
    .DataOutLast(DataOutLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_buffer();
    for (int i = 0; i < 16; i++) begin
      WrEn   = 1'b1;
      WrAddr = 4'(i);
      WrData = 32'h100 + 32'(i);
      tick();
    end
    WrEn = 1'b0;
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      check({tag, "_valid"}, 32'(DataOutValid), 32'd0);
      check({tag, "_busy"},  32'(Busy),         32'd0);
      check({tag, "_done"},  32'(Done),         32'd0);
    end
  endtask

  // Runs one job and checks every word; bp selects the 1,0,0,1,0,1 ready
  // pattern, disturb injects a Start and a write mid-job, simwr collides a
  // write with the accepted Start, zero expects an all-zero buffer.
  task automatic run_job(input string tag, input int sa, input int len,
                         input int bp, input int disturb, input int simwr,
                         input int zero);
    int          idx;
    int          cycles;
    int          n;
    logic        rdy;
    logic [31:0] exp;
    logic        pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    n = len * 4;
    Start     = 1'b1;
    StartAddr = 4'(sa);
    Length    = 5'(len);
    if (simwr != 0) begin
      WrEn   = 1'b1;
      WrAddr = 4'd2;
      WrData = 32'hDEAD;
    end
    tick();
    Start = 1'b0;
    WrEn  = 1'b0;
    check({tag, "_start_busy"}, 32'(Busy), 32'd1);
    idx = 0;
    cycles = 0;
    while (idx < n && cycles < 300) begin
      exp = (zero != 0) ? 32'd0 : 32'h100 + 32'((sa + (idx % len)) % 16);
      check({tag, "_valid"}, 32'(DataOutValid), 32'd1);
      check({tag, "_data"},  DataOut, exp);
      check({tag, "_last"},  32'(DataOutLast), 32'((idx % len) == len - 1));
      check({tag, "_nodone"}, 32'(Done), 32'd0);
      rdy = (bp != 0) ? pat[cycles % 6] : 1'b1;
      DataOutRdy = rdy;
      if (disturb != 0 && cycles == 2) begin
        Start     = 1'b1;
        StartAddr = 4'd0;
        Length    = 5'd1;
        WrEn      = 1'b1;
        WrAddr    = 4'd3;
        WrData    = 32'hBAD;
      end else if (disturb != 0 && cycles == 3) begin
        Start = 1'b0;
        WrEn  = 1'b0;
      end
      tick();
      cycles++;
      if (rdy) idx++;
    end
    Start = 1'b0;
    WrEn  = 1'b0;
    DataOutRdy = 1'b0;
    check({tag, "_budget"}, 32'(idx), 32'(n));
    check({tag, "_end_valid"}, 32'(DataOutValid), 32'd0);
    check({tag, "_end_done"},  32'(Done), 32'd1);
    check({tag, "_end_busy"},  32'(Busy), 32'd1);
    tick();
    check({tag, "_idle_done"}, 32'(Done), 32'd0);
    check({tag, "_idle_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    aclr = 1'b0;
    WrEn = 1'b0; WrAddr = '0; WrData = '0;
    Start = 1'b0; StartAddr = '0; Length = '0;
    DataOutRdy = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(DataOutValid), 32'd0);
    check("rst_busy",  32'(Busy), 32'd0);
    check("rst_done",  32'(Done), 32'd0);
    check("rst_data",  DataOut, 32'd0);
    check("rst_last",  32'(DataOutLast), 32'd0);
    aclr = 1'b1;
    tick();

    load_buffer();
    run_job("basic", 2, 3, 0, 0, 0, 0);
    run_job("wrap", 14, 4, 0, 0, 0, 0);
    run_job("bp", 2, 3, 1, 0, 0, 0);
    run_job("disturb", 2, 3, 0, 1, 0, 0);
    run_job("after_disturb", 2, 3, 0, 0, 0, 0);
    run_job("simwr", 2, 3, 0, 0, 1, 0);
    run_job("after_simwr", 1, 2, 0, 0, 0, 0);

    // Zero and oversize lengths are ignored.
    Start = 1'b1; StartAddr = 4'd2; Length = 5'd0;
    tick();
    Start = 1'b0;
    check("len0_valid", 32'(DataOutValid), 32'd0);
    idle_quiet("len0", 3);
    Start = 1'b1; StartAddr = 4'd2; Length = 5'd17;
    tick();
    Start = 1'b0;
    check("len17_valid", 32'(DataOutValid), 32'd0);
    idle_quiet("len17", 3);

    // Reset in the middle of a job.
    Start = 1'b1; StartAddr = 4'd2; Length = 5'd3;
    tick();
    Start = 1'b0;
    DataOutRdy = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("mid_valid_pre", 32'(DataOutValid), 32'd1);
    check("mid_data_pre", DataOut, 32'h104);
    aclr = 1'b0;
    #1;
    check("mid_rst_valid", 32'(DataOutValid), 32'd0);
    check("mid_rst_busy",  32'(Busy), 32'd0);
    check("mid_rst_done",  32'(Done), 32'd0);
    check("mid_rst_data",  DataOut, 32'd0);
    DataOutRdy = 1'b0;
    tick();
    check("mid_rst_hold_done", 32'(Done), 32'd0);
    aclr = 1'b1;
    idle_quiet("post_rst", 2);
    run_job("zero_buf", 0, 16, 0, 0, 0, 1);
    load_buffer();
    run_job("reload", 2, 3, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
